// File: rtl/alu_share_pkg.sv
// Shared types and widths for the ALU sharing controller.
package alu_share_pkg;

  localparam int unsigned ALU_OP_W   = 7;
  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned VEC_MODE_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   operator;
    logic [ALU_DATA_W-1:0] op_a;
    logic [ALU_DATA_W-1:0] op_b;
    logic [ALU_DATA_W-1:0] op_c;
    logic [VEC_MODE_W-1:0] vector_mode;
  } alu_req_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// ALU-side handshake and data bundle; master is the controller, slave is the ALU.
interface alu_share_ctrl_if;
  import alu_share_pkg::*;

  logic                  enable;
  logic                  ex_ready;
  alu_req_t              req;
  logic [ALU_DATA_W-1:0] result;
  logic                  cmp;
  logic                  ready;

  modport master (output enable, ex_ready, req, input result, cmp, ready);
  modport slave  (input enable, ex_ready, req, output result, cmp, ready);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid index at or above ptr_i, with wrap.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && valid_i[IdxW'(j)]) begin
        any_o = 1'b1;
        idx_o = IdxW'(j);
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU among NUM_REQ requesters with round-robin grant and an EXEC watchdog.
// Optional per-requester completion counters: define ALU_SHARE_CTRL_PERF_EN.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*ALU_OP_W-1:0]      req_operator_i,
  input  logic [NUM_REQ*ALU_DATA_W-1:0]    req_op_a_i,
  input  logic [NUM_REQ*ALU_DATA_W-1:0]    req_op_b_i,
  input  logic [NUM_REQ*ALU_DATA_W-1:0]    req_op_c_i,
  input  logic [NUM_REQ*VEC_MODE_W-1:0]    req_vector_mode_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [ALU_DATA_W-1:0]            rsp_result_o,
  output logic                             rsp_cmp_o,
  output logic                             rsp_err_o,
  alu_share_ctrl_if.master                 alu,
  output logic [NUM_REQ*32-1:0]            perf_cnt_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT);
  localparam logic [WdW-1:0] WdogLast = WdW'(TIMEOUT - 1);

  state_e                state_q;
  logic [IdxW-1:0]       rr_ptr_q, owner_q;
  alu_req_t              req_q;
  logic [WdW-1:0]        wdog_q;
  logic [ALU_DATA_W-1:0] result_q;
  logic                  cmp_q, err_q, alu_en_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;

  logic [NUM_REQ-1:0] pick_grant, owner_oh;
  logic [IdxW-1:0]    pick_idx, ptr_next;
  logic               pick_any, rsp_hs;
  alu_req_t           pick_req;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    pick_req.operator    = req_operator_i[int'(pick_idx)*ALU_OP_W +: ALU_OP_W];
    pick_req.op_a        = req_op_a_i[int'(pick_idx)*ALU_DATA_W +: ALU_DATA_W];
    pick_req.op_b        = req_op_b_i[int'(pick_idx)*ALU_DATA_W +: ALU_DATA_W];
    pick_req.op_c        = req_op_c_i[int'(pick_idx)*ALU_DATA_W +: ALU_DATA_W];
    pick_req.vector_mode = req_vector_mode_i[int'(pick_idx)*VEC_MODE_W +: VEC_MODE_W];
    ptr_next = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    owner_oh = NUM_REQ'(1) << owner_q;
    rsp_hs   = (state_q == StResp) && rsp_ready_i[owner_q];
  end

  // Gated by rst so the grant is also quiet while reset is held.
  assign req_ready_o = (state_q == StIdle && !rst) ? pick_grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      req_q       <= '0;
      wdog_q      <= '0;
      result_q    <= '0;
      cmp_q       <= 1'b0;
      err_q       <= 1'b0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_any) begin
            req_q    <= pick_req;
            owner_q  <= pick_idx;
            rr_ptr_q <= ptr_next;
            wdog_q   <= '0;
            alu_en_q <= 1'b1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          // ALU completion takes priority over a coincident watchdog expiry.
          if (alu.ready) begin
            result_q    <= alu.result;
            cmp_q       <= alu.cmp;
            err_q       <= 1'b0;
            alu_en_q    <= 1'b0;
            rsp_valid_q <= owner_oh;
            state_q     <= StResp;
          end else if (wdog_q == WdogLast) begin
            result_q    <= '0;
            cmp_q       <= 1'b0;
            err_q       <= 1'b1;
            alu_en_q    <= 1'b0;
            rsp_valid_q <= owner_oh;
            state_q     <= StResp;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_hs) begin
            rsp_valid_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu.enable   = alu_en_q;
  assign alu.ex_ready = alu_en_q;
  assign alu.req      = req_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_cmp_o    = cmp_q;
  assign rsp_err_o    = err_q;

`ifdef ALU_SHARE_CTRL_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (rsp_hs && !err_q) begin
      perf_q[owner_q] <= perf_q[owner_q] + 32'd1;
    end
  end

  assign perf_cnt_o = perf_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU model.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [6:0] OP_ADD = 7'b0011000;
  localparam logic [6:0] OP_DIV = 7'b0110001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]    req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [NUM_REQ*7-1:0]  req_operator = '0;
  logic [NUM_REQ*32-1:0] req_op_a = '0, req_op_b = '0, req_op_c = '0, perf_cnt;
  logic [NUM_REQ*2-1:0]  req_vector_mode = '0;
  logic [31:0]           rsp_result;
  logic                  rsp_cmp, rsp_err;

  alu_share_ctrl_if alu_if ();

  alu_share_ctrl #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_operator_i    (req_operator),
    .req_op_a_i        (req_op_a),
    .req_op_b_i        (req_op_b),
    .req_op_c_i        (req_op_c),
    .req_vector_mode_i (req_vector_mode),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_result_o      (rsp_result),
    .rsp_cmp_o         (rsp_cmp),
    .rsp_err_o         (rsp_err),
    .alu               (alu_if.master),
    .perf_cnt_o        (perf_cnt)
  );

  function automatic logic [31:0] alu_fn(logic [6:0] op, logic [31:0] a, logic [31:0] b);
    if (op == OP_ADD) return a + b;
    if (op == OP_DIV) return (b != 0) ? a / b : 32'hFFFF_FFFF;
    return a - b;
  endfunction

  // ALU model: ready after alu_delay EXEC cycles, never when stuck.
  int unsigned alu_delay = 0;
  bit          alu_stuck = 1'b0;
  int unsigned exec_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) exec_cnt <= 0;
    else if (alu_if.enable) exec_cnt <= exec_cnt + 1;
    else exec_cnt <= 0;
  end
  assign alu_if.ready  = alu_if.enable && !alu_stuck && (exec_cnt >= alu_delay);
  assign alu_if.result = alu_fn(alu_if.req.operator, alu_if.req.op_a, alu_if.req.op_b);
  assign alu_if.cmp    = alu_if.req.op_a < alu_if.req.op_b;

  int checks = 0;
  int fails  = 0;

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          owner;
    logic [31:0] result;
    logic        cmp;
    logic        err;
  } exp_t;

  exp_t               sb[$];
  int                 grant_log[$];
  int                 rsp_cyc[$];
  int                 perf_model[NUM_REQ];
  logic [NUM_REQ-1:0] acc_mask = '0;
  int                 cyc = 0;

  // Monitor: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      acc_mask = '0;
    end else begin
      acc_mask = req_valid & req_ready;
      if (acc_mask != 0) check_eq("grant_onehot", 64'($onehot(acc_mask)), 64'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i]) begin
          e.owner  = i;
          e.err    = alu_stuck;
          e.result = alu_stuck ? 32'd0 :
                     alu_fn(req_operator[i*7 +: 7], req_op_a[i*32 +: 32], req_op_b[i*32 +: 32]);
          e.cmp    = alu_stuck ? 1'b0 : (req_op_a[i*32 +: 32] < req_op_b[i*32 +: 32]);
          sb.push_back(e);
          grant_log.push_back(i);
        end
      end
      if (rsp_valid != 0 && (rsp_valid & rsp_ready) != 0) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_owner", 64'(rsp_valid), 64'(1 << e.owner));
          check_eq("rsp_result", 64'(rsp_result), 64'(e.result));
          check_eq("rsp_cmp", 64'(rsp_cmp), 64'(e.cmp));
          check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
          if (!e.err) perf_model[e.owner]++;
          rsp_cyc.push_back(cyc);
        end
      end
    end
  end

  logic [NUM_REQ-1:0] keep_busy = '0;

  task automatic set_req(int i, logic [6:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                         logic [1:0] vm);
    req_operator[i*7 +: 7]   = op;
    req_op_a[i*32 +: 32]     = a;
    req_op_b[i*32 +: 32]     = b;
    req_op_c[i*32 +: 32]     = c;
    req_vector_mode[i*2 +: 2] = vm;
    req_valid[i]             = 1'b1;
  endtask

  // Advance one cycle; retire accepted requests, reissuing for busy requesters.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_mask[i]) begin
        req_valid[i] = 1'b0;
        if (keep_busy[i]) set_req(i, OP_ADD, $urandom, $urandom, $urandom, 2'($urandom_range(3)));
      end
    end
  endtask

  task automatic wait_idle(int bound);
    bit done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      if (req_valid == 0 && rsp_valid == 0 && !alu_if.enable && sb.size() == 0) done = 1'b1;
      else tick();
    end
    if (!done) check_eq("idle_timeout", 64'd0, 64'd1);
  endtask

  // Counts EXEC cycles until a response appears; checks held ALU inputs meanwhile.
  task automatic count_exec(logic [6:0] op, logic [31:0] a, output int n, output bit stable);
    n = 0;
    stable = 1'b1;
    while (rsp_valid == 0 && n < 200) begin
      if (alu_if.enable) n++;
      if (!alu_if.enable || !alu_if.ex_ready || req_ready != 0 ||
          alu_if.req.operator != op || alu_if.req.op_a != a) stable = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n;
    bit stable, no_grant;
    logic [31:0] snap_res;
    logic        snap_cmp;
    logic [31:0] snap_perf;

    for (int i = 0; i < NUM_REQ; i++) perf_model[i] = 0;

    // Reset: outputs quiet even with requests present.
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_alu_enable", 64'(alu_if.enable), 64'd0);
    check_eq("rst_result", 64'(rsp_result), 64'd0);
    check_eq("rst_err", 64'(rsp_err), 64'd0);
    check_eq("rst_perf", 64'(perf_cnt), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Single ADD with same-cycle ALU ready.
    set_req(0, OP_ADD, 32'd5, 32'd7, 32'd0, 2'd0);
    #1 check_eq("t1_req_ready", 64'(req_ready), 64'b01);
    tick();
    check_eq("t1_exec_enable", 64'(alu_if.enable), 64'd1);
    check_eq("t1_exec_op_a", 64'(alu_if.req.op_a), 64'd5);
    check_eq("t1_exec_no_ready", 64'(req_ready), 64'd0);
    tick();
    check_eq("t1_rsp_valid", 64'(rsp_valid), 64'b01);
    check_eq("t1_rsp_result", 64'(rsp_result), 64'd12);
    check_eq("t1_rsp_err", 64'(rsp_err), 64'd0);
    wait_idle(20);

    // Both requesters continuously busy; req0 was granted last so req1 goes first.
    grant_log.delete();
    rsp_cyc.delete();
    keep_busy = '1;
    set_req(0, OP_ADD, $urandom, $urandom, 32'd0, 2'd0);
    set_req(1, OP_ADD, $urandom, $urandom, 32'd0, 2'd1);
    repeat (14) tick();
    keep_busy = '0;
    req_valid = '0;
    wait_idle(20);
    check_eq("t2_grant_count", 64'(grant_log.size() >= 4), 64'd1);
    if (grant_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) check_eq("t2_grant_order", 64'(grant_log[k]), 64'((k + 1) % 2));
    end
    if (rsp_cyc.size() >= 4) begin
      for (int k = 0; k < 3; k++) check_eq("t2_rsp_spacing", 64'(rsp_cyc[k+1] - rsp_cyc[k]), 64'd3);
    end

    // Long DIV: inputs held through 35 not-ready cycles, req1 waits meanwhile.
    alu_delay = 35;
    set_req(0, OP_DIV, 32'd1000, 32'd7, 32'd3, 2'd1);
    #1 check_eq("t3_req_ready", 64'(req_ready), 64'b01);
    tick();
    set_req(1, OP_ADD, 32'd1, 32'd2, 32'd0, 2'd0);
    count_exec(OP_DIV, 32'd1000, n, stable);
    check_eq("t3_exec_cycles", 64'(n), 64'd36);
    check_eq("t3_inputs_stable", 64'(stable), 64'd1);
    check_eq("t3_rsp_result", 64'(rsp_result), 64'd142);
    alu_delay = 0;
    wait_idle(30);

    // Response backpressure; non-owner rsp_ready must be ignored.
    rsp_ready = 2'b01;
    set_req(1, OP_ADD, 32'd100, 32'd20, 32'd0, 2'd0);
    repeat (3) tick();
    check_eq("t4_rsp_valid", 64'(rsp_valid), 64'b10);
    snap_res = rsp_result;
    snap_cmp = rsp_cmp;
    set_req(0, OP_ADD, 32'd3, 32'd4, 32'd0, 2'd0);
    stable   = 1'b1;
    no_grant = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid != 2'b10 || rsp_result != snap_res || rsp_cmp != snap_cmp) stable = 1'b0;
      if (req_ready != 0 || alu_if.enable) no_grant = 1'b0;
      tick();
    end
    check_eq("t4_rsp_stable", 64'(stable), 64'd1);
    check_eq("t4_no_grant", 64'(no_grant), 64'd1);
    check_eq("t4_result", 64'(snap_res), 64'd120);
    rsp_ready = '1;
    wait_idle(30);

    // Watchdog: ALU never ready.
    alu_stuck = 1'b1;
    snap_perf = perf_cnt[31:0];
    set_req(0, OP_ADD, 32'd9, 32'd9, 32'd0, 2'd0);
    tick();
    count_exec(OP_ADD, 32'd9, n, stable);
    check_eq("t5_exec_cycles", 64'(n), 64'(TIMEOUT));
    check_eq("t5_rsp_err", 64'(rsp_err), 64'd1);
    check_eq("t5_rsp_result", 64'(rsp_result), 64'd0);
    wait_idle(20);
    alu_stuck = 1'b0;
`ifdef ALU_SHARE_CTRL_PERF_EN
    check_eq("t5_perf_unchanged", 64'(perf_cnt[31:0]), 64'(snap_perf));
`else
    check_eq("t5_perf_tied", 64'(perf_cnt), 64'd0);
`endif

    // Reset in the middle of EXEC: outputs drop without a clock edge.
    alu_delay = 20;
    set_req(0, OP_ADD, 32'd1, 32'd1, 32'd0, 2'd0);
    repeat (3) tick();
    check_eq("t6_in_exec", 64'(alu_if.enable), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    for (int i = 0; i < NUM_REQ; i++) perf_model[i] = 0;
    #1;
    check_eq("t6_async_enable", 64'(alu_if.enable), 64'd0);
    check_eq("t6_async_rsp_valid", 64'(rsp_valid), 64'd0);
    req_valid = '0;
    alu_delay = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    check_eq("t6_no_stale_rsp", 64'(rsp_valid), 64'd0);
    set_req(0, OP_ADD, 32'd2, 32'd3, 32'd0, 2'd0);
    set_req(1, OP_ADD, 32'd4, 32'd5, 32'd0, 2'd0);
    #1 check_eq("t6_ptr_reset", 64'(req_ready), 64'b01);
    tick();
    wait_idle(30);

`ifdef ALU_SHARE_CTRL_PERF_EN
    for (int i = 0; i < NUM_REQ; i++)
      check_eq("perf_final", 64'(perf_cnt[i*32 +: 32]), 64'(perf_model[i]));
`endif
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
